triangle_setup: RTL
===================

# triangle_setup

Per-triangle setup stage directly upstream of the rasterizer. Accepts three screen-space vertices plus a color over a valid/ready handshake and computes everything the rasterizer needs:

- three edge-equation coefficient sets,
- bounding box,
- reordered vertex Z values,
- Q24 reciprocal of twice the signed area.

It then launches the rasterizer with a one-cycle start pulse and holds all outputs stable until the rasterizer reports done. It replaces the per-triangle setup arithmetic currently done in software.

## Interface
Parameters:
- SCREEN_W, 320, horizontal resolution; vertex x valid range 0..SCREEN_W-1
- SCREEN_H, 240, vertical resolution; vertex y valid range 0..SCREEN_H-1
- DIV_BITS, 25, quotient bits produced by the divider; one bit per cycle

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- tri_valid  in  1  vertex data valid.
- tri_ready  out  1  block idle; accepts when tri_valid && tri_ready.
- vx0, vx1, vx2  in  9 each  unsigned vertex x.
- vy0, vy1, vy2  in  8 each  unsigned vertex y.
- vz0, vz1, vz2  in  16 each  unsigned vertex depth.
- tri_color  in  8  triangle color.
- a1, b1, a2, b2, a3, b3  out  9 each  signed edge coefficients.
- c1, c2, c3  out  18 each  signed edge constants.
- bbxi, bbxf  out  9 each  bounding-box x min / max.
- bbyi, bbyf  out  8 each  bounding-box y min / max.
- z1, z2, z3  out  16 each  depths paired with e1, e2, e3.
- inv_area  out  32  floor(2^24 / |area2|), zero-extended.
- color  out  8  latched tri_color.
- rasterizer_start  out  1  one-cycle launch pulse.
- rasterizer_done  in  1  one-cycle completion pulse from the rasterizer.
- tri_count  out  16  triangles issued; wraps.
- drop_count  out  16  triangles dropped; wraps.

## Operation
States and transitions:
- IDLE: tri_ready = 1. On accept, latch all vertex inputs and tri_color → SETUP1.
- SETUP1: compute the edge coefficients and cross products → SETUP2.
  - Edge 1 (v0→v1): a1 = vy0−vy1, b1 = vx1−vx0, c1 = vx0·vy1 − vx1·vy0.
  - Edge 2 (v1→v2): same form using v1, v2.
  - Edge 3 (v2→v0): same form using v2, v0.
- SETUP2: compute area2 = (vx1−vx0)(vy2−vy0) − (vx2−vx0)(vy1−vy0), 19-bit signed. Compute the bounding box as min/max of the vertex x and y values → CHECK.
- CHECK: drop the triangle (drop_count+1 → IDLE) if any of the following holds:
  - any vx ≥ SCREEN_W or any vy ≥ SCREEN_H;
  - area2 == 0;
  - any raw b outside −255..255;
  - area2 < 0 and the cull feature is enabled.
  
  Otherwise: if area2 < 0, negate all a, b, c. Load the divider with dividend 2^24 and divisor |area2| → DIVIDE.
- DIVIDE: restoring division, one quotient bit per cycle, DIV_BITS cycles → ISSUE.
- ISSUE: assert rasterizer_start for one cycle; tri_count+1 → WAIT_DONE.
- WAIT_DONE: hold; on rasterizer_done → IDLE.

Depth pairing (each z output is the depth of the vertex opposite the matching edge):
- z1 = vz2
- z2 = vz0
- z3 = vz1

Output stability: all coefficient, bounding-box, z, color and inv_area outputs change only in SETUP1 through DIVIDE. They are held constant from ISSUE through WAIT_DONE, and after that until the next accept.

## Timing
- Reset values: tri_ready = 1; every other output and counter = 0; state = IDLE.
- Reset is effective immediately, including mid-DIVIDE or in WAIT_DONE; no start pulse is emitted after it.
- Accept occurs on clock edge E0.
- Launch path: rasterizer_start is high for exactly the one cycle following edge E0+28 (SETUP1, SETUP2, CHECK, then 25 DIVIDE cycles).
- Drop path: tri_ready returns high after edge E0+3.
- tri_ready is low from the cycle after accept until the edge that samples rasterizer_done in WAIT_DONE. It is high in the following cycle.
- rasterizer_done outside WAIT_DONE is ignored.
- tri_valid while tri_ready is low is not accepted; the vertex inputs may change freely during that time.

## Configuration
- BACKFACE_CULL_EN defined: triangles with area2 < 0 are dropped and counted in drop_count.
- BACKFACE_CULL_EN undefined: both windings are rasterized; negative-area triangles have a, b, c negated so that all interior pixels give E ≥ 0.
- area2 == 0 is dropped in both builds.

## Test plan
- v0 = (10,10,z=100), v1 = (50,10,z=200), v2 = (10,50,z=300) → single start pulse 28 edges after accept, with:
  - a1 = 0, b1 = 40, c1 = −400
  - a2 = −40, b2 = −40, c2 = 2400
  - a3 = 40, b3 = 0, c3 = −400
  - bbox = 10..50 × 10..50
  - z1 = 300, z2 = 100, z3 = 200
  - inv_area = 10485
  - tri_count = 1
- Same triangle with v1 and v2 swapped (area2 = −1600):
  - with BACKFACE_CULL_EN: no start pulse, drop_count = 1, tri_ready high after E0+3.
  - without it: a, b, c are the negation of the raw swapped-order values, inv_area = 10485, and a start pulse is issued.
- Collinear (0,0), (10,10), (20,20) → dropped in both builds; drop_count increments.
- v0 = (0,0), v1 = (300,0), v2 = (0,100) (b1 = 300) → dropped. Separately, vx0 = 320 → dropped.
- Hold tri_valid high with a second triangle while in WAIT_DONE; pulse rasterizer_done 500 cycles later → all outputs stay constant for the whole 500 cycles. Second accept occurs exactly one cycle after the done edge.
- Assert rst low during DIVIDE cycle 10 → all outputs 0, tri_ready = 1. After release, no rasterizer_start pulse occurs until a new accept.

Source files
------------

// File: rtl/triangle_setup_if.sv
// triangle_setup_if: triangle input bus into the setup stage.
// Handshake: the master holds tri_valid and the vertex/color fields steady
// while offering a triangle; a transfer happens on every rising clock edge
// where tri_valid && tri_ready are both high. The fields are don't-care
// whenever tri_ready is low, and tri_valid may be held high across a busy
// period without being taken.
interface triangle_setup_if;
    logic        tri_valid;
    logic        tri_ready;
    logic [8:0]  vx0, vx1, vx2;
    logic [7:0]  vy0, vy1, vy2;
    logic [15:0] vz0, vz1, vz2;
    logic [7:0]  tri_color;

    modport master (
        output tri_valid, vx0, vx1, vx2, vy0, vy1, vy2, vz0, vz1, vz2, tri_color,
        input  tri_ready
    );

    modport slave (
        input  tri_valid, vx0, vx1, vx2, vy0, vy1, vy2, vz0, vz1, vz2, tri_color,
        output tri_ready
    );
endinterface

// File: rtl/triangle_setup.sv
// triangle_setup: per-triangle setup ahead of the rasterizer. Latches one
// triangle, derives edge equations, bounding box, paired depths and the Q24
// reciprocal of twice the signed area, then launches the rasterizer and holds
// every result until the rasterizer reports done.
// Optional build macro BACKFACE_CULL_EN: when defined, negative-area
// triangles are dropped instead of being flipped and rasterized.
module triangle_setup #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int DIV_BITS = 25
) (
    input  logic               clk,
    input  logic               rst,
    triangle_setup_if.slave    tri_in,
    output logic signed [8:0]  a1, b1, a2, b2, a3, b3,
    output logic signed [17:0] c1, c2, c3,
    output logic [8:0]         bbxi, bbxf,
    output logic [7:0]         bbyi, bbyf,
    output logic [15:0]        z1, z2, z3,
    output logic [31:0]        inv_area,
    output logic [7:0]         color,
    output logic               rasterizer_start,
    input  logic               rasterizer_done,
    output logic [15:0]        tri_count,
    output logic [15:0]        drop_count,
    output logic [2:0]         state_dbg
);

    localparam int                CNT_W    = $clog2(DIV_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_BITS - 1);
    localparam logic [8:0]        X_LIM    = 9'(SCREEN_W);
    localparam logic [7:0]        Y_LIM    = 8'(SCREEN_H);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP1    = 3'd1,
        SETUP2    = 3'd2,
        CHECK     = 3'd3,
        DIVIDE    = 3'd4,
        ISSUE     = 3'd5,
        WAIT_DONE = 3'd6
    } state_t;

    state_t state_q, state_d;

    // Latched vertex coordinates.
    logic [8:0] vx0_q, vx1_q, vx2_q;
    logic [7:0] vy0_q, vy1_q, vy2_q;

    // Raw b values keep one extra bit so out-of-range edges can be detected.
    logic signed [9:0]  b1_q, b2_q, b3_q;
    logic signed [18:0] p1_q, p2_q, area2_q;

    // Divider state: quo_q starts as the dividend and fills with quotient bits.
    logic [DIV_BITS-1:0] quo_q;
    logic [18:0]         rem_q, divisor_q;
    logic [CNT_W-1:0]    div_cnt_q;
    logic [19:0]         rem_shift;
    logic                div_ge;

    logic signed [19:0] sx0, sx1, sx2, sy0, sy1, sy2;
    logic               accept, coord_bad, b_bad, cull_drop, drop;

    function automatic logic [8:0] min3(input logic [8:0] p, input logic [8:0] q, input logic [8:0] r);
        logic [8:0] m;
        m = (p < q) ? p : q;
        return (m < r) ? m : r;
    endfunction

    function automatic logic [8:0] max3(input logic [8:0] p, input logic [8:0] q, input logic [8:0] r);
        logic [8:0] m;
        m = (p > q) ? p : q;
        return (m > r) ? m : r;
    endfunction

    function automatic logic b_out(input logic signed [9:0] b);
        return (b > 10'sd255) || (b < -10'sd255);
    endfunction

    assign sx0 = 20'(vx0_q);
    assign sx1 = 20'(vx1_q);
    assign sx2 = 20'(vx2_q);
    assign sy0 = 20'(vy0_q);
    assign sy1 = 20'(vy1_q);
    assign sy2 = 20'(vy2_q);

    assign b1 = b1_q[8:0];
    assign b2 = b2_q[8:0];
    assign b3 = b3_q[8:0];

    assign state_dbg = state_q;
    assign accept    = (state_q == IDLE) && tri_in.tri_valid;

    assign rem_shift = {rem_q, quo_q[DIV_BITS-1]};
    assign div_ge    = rem_shift >= {1'b0, divisor_q};

    // Rejection conditions evaluated in CHECK from values settled in SETUP1/SETUP2.
    always_comb begin
        coord_bad = (vx0_q >= X_LIM) || (vx1_q >= X_LIM) || (vx2_q >= X_LIM) ||
                    (vy0_q >= Y_LIM) || (vy1_q >= Y_LIM) || (vy2_q >= Y_LIM);
        b_bad     = b_out(b1_q) || b_out(b2_q) || b_out(b3_q);
`ifdef BACKFACE_CULL_EN
        cull_drop = area2_q[18];
`else
        cull_drop = 1'b0;
`endif
        drop      = coord_bad || (area2_q == 19'sd0) || b_bad || cull_drop;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state and handshake/launch outputs.
    always_comb begin
        state_d          = state_q;
        tri_in.tri_ready = 1'b0;
        rasterizer_start = 1'b0;
        case (state_q)
            IDLE: begin
                tri_in.tri_ready = 1'b1;
                if (tri_in.tri_valid) state_d = SETUP1;
            end
            SETUP1:    state_d = SETUP2;
            SETUP2:    state_d = CHECK;
            CHECK:     state_d = drop ? IDLE : DIVIDE;
            DIVIDE:    if (div_cnt_q == CNT_LAST) state_d = ISSUE;
            ISSUE: begin
                rasterizer_start = 1'b1;
                state_d          = WAIT_DONE;
            end
            WAIT_DONE: if (rasterizer_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Setup datapath: latch, edge equations, area/bbox, sign fix-up, divider, counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vx0_q <= '0; vx1_q <= '0; vx2_q <= '0;
            vy0_q <= '0; vy1_q <= '0; vy2_q <= '0;
            a1 <= '0; a2 <= '0; a3 <= '0;
            b1_q <= '0; b2_q <= '0; b3_q <= '0;
            c1 <= '0; c2 <= '0; c3 <= '0;
            p1_q <= '0; p2_q <= '0; area2_q <= '0;
            bbxi <= '0; bbxf <= '0; bbyi <= '0; bbyf <= '0;
            z1 <= '0; z2 <= '0; z3 <= '0;
            color <= '0;
            inv_area <= '0;
            quo_q <= '0; rem_q <= '0; divisor_q <= '0; div_cnt_q <= '0;
            tri_count <= '0;
            drop_count <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        vx0_q <= tri_in.vx0; vx1_q <= tri_in.vx1; vx2_q <= tri_in.vx2;
                        vy0_q <= tri_in.vy0; vy1_q <= tri_in.vy1; vy2_q <= tri_in.vy2;
                        // Each depth belongs to the vertex opposite its edge.
                        z1    <= tri_in.vz2;
                        z2    <= tri_in.vz0;
                        z3    <= tri_in.vz1;
                        color <= tri_in.tri_color;
                    end
                end
                SETUP1: begin
                    a1   <= 9'(sy0 - sy1);
                    b1_q <= 10'(sx1 - sx0);
                    c1   <= 18'(sx0 * sy1 - sx1 * sy0);
                    a2   <= 9'(sy1 - sy2);
                    b2_q <= 10'(sx2 - sx1);
                    c2   <= 18'(sx1 * sy2 - sx2 * sy1);
                    a3   <= 9'(sy2 - sy0);
                    b3_q <= 10'(sx0 - sx2);
                    c3   <= 18'(sx2 * sy0 - sx0 * sy2);
                    p1_q <= 19'((sx1 - sx0) * (sy2 - sy0));
                    p2_q <= 19'((sx2 - sx0) * (sy1 - sy0));
                end
                SETUP2: begin
                    area2_q <= p1_q - p2_q;
                    bbxi    <= min3(vx0_q, vx1_q, vx2_q);
                    bbxf    <= max3(vx0_q, vx1_q, vx2_q);
                    bbyi    <= 8'(min3(9'(vy0_q), 9'(vy1_q), 9'(vy2_q)));
                    bbyf    <= 8'(max3(9'(vy0_q), 9'(vy1_q), 9'(vy2_q)));
                end
                CHECK: begin
                    if (drop) begin
                        drop_count <= drop_count + 16'd1;
                    end else begin
                        // Clockwise winding: flip every edge so interior pixels give E >= 0.
                        if (area2_q[18]) begin
                            a1 <= -a1; a2 <= -a2; a3 <= -a3;
                            b1_q <= -b1_q; b2_q <= -b2_q; b3_q <= -b3_q;
                            c1 <= -c1; c2 <= -c2; c3 <= -c3;
                        end
                        divisor_q <= area2_q[18] ? 19'(-area2_q) : 19'(area2_q);
                        rem_q     <= '0;
                        quo_q     <= {1'b1, {(DIV_BITS-1){1'b0}}};
                        div_cnt_q <= '0;
                    end
                end
                DIVIDE: begin
                    quo_q     <= {quo_q[DIV_BITS-2:0], div_ge};
                    rem_q     <= div_ge ? 19'(rem_shift - {1'b0, divisor_q}) : rem_shift[18:0];
                    div_cnt_q <= div_cnt_q + 1'b1;
                    if (div_cnt_q == CNT_LAST) inv_area <= 32'({quo_q[DIV_BITS-2:0], div_ge});
                end
                ISSUE: tri_count <= tri_count + 16'd1;
                default: ;
            endcase
        end
    end

endmodule
